lcd_read_fsm: RTL and testbench

Read-side sequencer for the 4-bit LCD character-module bus: performs one HD44780-style read transaction (busy-flag/address read or data-RAM read) as two nibble cycles with RW=1, samples the module's data pins on each E pulse, and assembles the byte. An optional busy-poll mode repeats busy-flag reads until BF clears. It sits beside the write command sequencer. While `rd_active` is high, the top level releases the FPGA SF_D drivers and muxes this block's E/RS/RW onto the pins.

---
 rtl/lcd_read_fsm.sv | 197 +++++++++++++++++++
 tb/tb_lcd_read_fsm.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_read_fsm.sv
// -----------------------------------------------------------------------------
// lcd_read_fsm
//
// Read-side sequencer for the 4-bit HD44780-style LCD bus. One accepted start
// performs a full read (busy-flag/address when rs_sel=0, data RAM when
// rs_sel=1) as two nibble cycles with RW=1. The module's data pins are sampled
// on the last E-high cycle of each nibble and the two nibbles are assembled
// into data_out. In busy-poll mode (poll=1 with rs_sel=0) the read repeats
// until the busy flag (bit 7) reads back clear.
//
// While rd_active is high the top level releases the SF_D drivers and muxes
// LCD_E/LCD_RS/LCD_RW from this block onto the pins.
//
// Optional build macro:
//   LCD_RD_TIMEOUT_EN - bound busy polling to POLL_MAX reads; when the limit
//                       is reached with BF still set, complete anyway and
//                       pulse timeout with data_valid. Undefined: polling is
//                       unbounded and timeout is tied 0 (port list unchanged).
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high
//   start      in   read request, sampled only in IDLE
//   rs_sel     in   0 = busy flag/address read, 1 = data read (latched)
//   poll       in   busy-poll mode, effective only with rs_sel=0 (latched)
//   lcd_db_in  in   [3:0] SF_D[11:8] pin inputs
//   LCD_E      out  enable strobe
//   LCD_RS     out  register select
//   LCD_RW     out  read/write, always 1 (read)
//   rd_active  out  high whenever the sequencer is not idle
//   data_out   out  [7:0] last assembled byte, held until next completion
//   data_valid out  one-cycle completion pulse
//   busy_flag  out  bit 7 of the last completed byte
//   timeout    out  one-cycle pulse with data_valid when polling gave up
// -----------------------------------------------------------------------------
module lcd_read_fsm #(
  parameter int SETUP_CYC  = 2,
  parameter int E_HIGH_CYC = 12,
  parameter int HOLD_CYC   = 1,
  parameter int GAP_CYC    = 50,
  parameter int POLL_MAX   = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs_sel,
  input  logic       poll,
  input  logic [3:0] lcd_db_in,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       rd_active,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy_flag,
  output logic       timeout
);

  // One counter width serves both the phase timer and the poll counter.
  localparam int MAX_A = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int MAX_B = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_P = (MAX_C > POLL_MAX) ? MAX_C : POLL_MAX;
  localparam int CNT_W = $clog2(MAX_P + 1);

  // Encoding is sequential: each timed state advances to state + 1, with
  // RECOVER handled explicitly.
  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] SETUP_U = 4'd1;
  localparam logic [3:0] E_U     = 4'd2;
  localparam logic [3:0] HOLD_U  = 4'd3;
  localparam logic [3:0] GAP     = 4'd4;
  localparam logic [3:0] SETUP_L = 4'd5;
  localparam logic [3:0] E_L     = 4'd6;
  localparam logic [3:0] HOLD_L  = 4'd7;
  localparam logic [3:0] RECOVER = 4'd8;

  logic [3:0]       state;
  logic [CNT_W-1:0] cnt;      // cycles remaining in the current state, minus one
  logic             rs_q;
  logic             poll_q;
  logic [3:0]       nib_hi;
  logic [3:0]       nib_lo;
  logic             again;    // captured byte says "still busy, read again"

  // Timer reload value for a state: its cycle count minus one, so the state
  // exits on the edge where cnt is already zero.
  function automatic logic [CNT_W-1:0] load_for(input logic [3:0] s);
    case (s)
      SETUP_U, SETUP_L: load_for = CNT_W'(SETUP_CYC - 1);
      E_U, E_L:         load_for = CNT_W'(E_HIGH_CYC - 1);
      HOLD_U, HOLD_L:   load_for = CNT_W'(HOLD_CYC - 1);
      GAP, RECOVER:     load_for = CNT_W'(GAP_CYC - 1);
      default:          load_for = '0;
    endcase
  endfunction

  assign again = poll_q & ~rs_q & nib_hi[3];

`ifdef LCD_RD_TIMEOUT_EN
  logic [CNT_W-1:0] poll_cnt;   // repeats issued so far; reads done = poll_cnt + 1
  logic             timeout_q;
  logic             give_up;

  assign give_up = again && (poll_cnt == CNT_W'(POLL_MAX - 1));
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every register below is updated with non-blocking assignments so all
  // state moves together on the edge; blocking here would let later lines see
  // half-updated values and break simulation/synthesis equivalence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rs_q       <= 1'b0;
      poll_q     <= 1'b0;
      nib_hi     <= 4'h0;
      nib_lo     <= 4'h0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
`ifdef LCD_RD_TIMEOUT_EN
      poll_cnt   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
`ifdef LCD_RD_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            rs_q   <= rs_sel;
            poll_q <= poll;
`ifdef LCD_RD_TIMEOUT_EN
            poll_cnt <= '0;
`endif
            state  <= SETUP_U;
            cnt    <= load_for(SETUP_U);
          end
        end

        RECOVER: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
`ifdef LCD_RD_TIMEOUT_EN
            if (again && !give_up) begin
              poll_cnt <= poll_cnt + 1'b1;
              state    <= SETUP_U;
              cnt      <= load_for(SETUP_U);
            end else begin
              data_out   <= {nib_hi, nib_lo};
              data_valid <= 1'b1;
              timeout_q  <= give_up;
              state      <= IDLE;
            end
`else
            if (again) begin
              state <= SETUP_U;
              cnt   <= load_for(SETUP_U);
            end else begin
              data_out   <= {nib_hi, nib_lo};
              data_valid <= 1'b1;
              state      <= IDLE;
            end
`endif
          end
        end

        default: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Pins are sampled on the edge leaving the E-high phase, i.e.
            // while E is still high on the bus.
            if (state == E_U) nib_hi <= lcd_db_in;
            if (state == E_L) nib_lo <= lcd_db_in;
            state <= state + 4'd1;
            cnt   <= load_for(state + 4'd1);
          end
        end
      endcase
    end
  end

  // Moore decodes of the registered state.
  assign LCD_E     = (state == E_U) || (state == E_L);
  assign LCD_RS    = rs_q && (state inside {SETUP_U, E_U, HOLD_U, SETUP_L, E_L, HOLD_L});
  assign LCD_RW    = 1'b1;
  assign rd_active = (state != IDLE);
  assign busy_flag = data_out[7];

endmodule

// File: tb/tb_lcd_read_fsm.sv
// -----------------------------------------------------------------------------
// tb_lcd_read_fsm
//
// Scoreboard bench for lcd_read_fsm. A pin model answers each E pulse from a
// small nibble table; each launched read pushes its expected byte, timeout
// flag and completion cycle, and a monitor pops and compares on data_valid.
// A second monitor checks every E pulse width and RS during E.
// -----------------------------------------------------------------------------
module tb_lcd_read_fsm;

  localparam int T_READ = 130;
  localparam int E_HIGH = 12;

  typedef struct {
    logic [7:0] d;
    logic       to;
    int         at;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rs_sel = 1'b0;
  logic       poll = 1'b0;
  logic [3:0] lcd_db_in;
  logic       LCD_E, LCD_RS, LCD_RW, rd_active, data_valid, busy_flag, timeout;
  logic [7:0] data_out;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb[$];

  // Pin model state
  logic [3:0] up_tab [0:7];
  logic [3:0] lo_val = 4'h0;
  int         e_count = 0;
  int         base_e = 0;
  logic       exp_rs = 1'b0;

  // E monitor state
  int   e_hi = 0;
  logic e_prev = 1'b0;
  logic rs_at_e = 1'b0;

  lcd_read_fsm #(.POLL_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rs_sel    (rs_sel),
    .poll      (poll),
    .lcd_db_in (lcd_db_in),
    .LCD_E     (LCD_E),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .rd_active (rd_active),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy_flag (busy_flag),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pin model: even pulses since launch are upper nibbles (one per read),
  // odd pulses are the lower nibble.
  always_comb begin
    int k;
    int r;
    k = e_count - base_e;
    r = (k / 2 > 7) ? 7 : k / 2;
    if (k % 2 == 0) lcd_db_in = up_tab[r];
    else            lcd_db_in = lo_val;
  end

  // E pulse monitor
  always @(negedge clk) begin
    if (reset) begin
      e_hi   <= 0;
      e_prev <= 1'b0;
    end else begin
      if (LCD_E) begin
        e_hi    <= e_hi + 1;
        rs_at_e <= LCD_RS;
      end else if (e_prev) begin
        check("e_width", e_hi, E_HIGH);
        check("rs_during_e", rs_at_e, exp_rs);
        e_count <= e_count + 1;
        e_hi    <= 0;
      end
      e_prev <= LCD_E;
    end
  end

  // Completion monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!reset && data_valid) begin
      if (sb.size() == 0) begin
        check("dv_unexpected", data_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("data_out", data_out, e.d);
        check("busy_flag", busy_flag, e.d[7]);
        check("timeout", timeout, e.to);
        check("dv_cycle", cyc, e.at);
      end
    end
  end

  // Start a read; returns N, the count of the accepting edge.
  task automatic launch(input logic rs, input logic pl, output int n);
    @(negedge clk);
    check("idle_before_start", rd_active, 1'b0);
    rs_sel = rs;
    poll   = pl;
    exp_rs = rs;
    base_e = e_count;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = cyc;
    check("rd_active_rise", rd_active, 1'b1);
  endtask

  task automatic expect_read(input int n, input int reads, input logic [7:0] d, input logic to);
    exp_t e;
    e.d  = d;
    e.to = to;
    e.at = n + reads * T_READ;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("dv_seen", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int n;
    logic to_seen;
    for (int i = 0; i < 8; i++) up_tab[i] = 4'h0;

    // ---- Reset, including a reset asserted mid-idle ----
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_lcd_e", LCD_E, 1'b0);
    check("rst_lcd_rs", LCD_RS, 1'b0);
    check("rst_lcd_rw", LCD_RW, 1'b1);
    check("rst_rd_active", rd_active, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_busy_flag", busy_flag, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    repeat (20) @(negedge clk);
    check("idle_no_activity", {LCD_E, rd_active}, 2'b00);

    // ---- Data read: 0x4/0x1 -> 0x41 at N+130 ----
    up_tab[0] = 4'h4;
    lo_val    = 4'h1;
    launch(1'b1, 1'b0, n);
    expect_read(n, 1, 8'h41, 1'b0);
    wait_until(n + 1);
    check("e_low_n1", LCD_E, 1'b0);
    check("rw_read", LCD_RW, 1'b1);
    wait_until(n + 2);
    check("e_rise_n2", LCD_E, 1'b1);
    wait_until(n + 14);
    check("e_fall_n14", LCD_E, 1'b0);
    wait_until(n + 67);
    check("e_rise_n67", LCD_E, 1'b1);
    wait_until(n + 79);
    check("e_fall_n79", LCD_E, 1'b0);
    wait_done(200);
    repeat (5) @(negedge clk);
    check("data_out_hold", data_out, 8'h41);
    check("idle_after_read", rd_active, 1'b0);

    // ---- Busy poll: BF set for two reads, then 0x05 at N+390 ----
    up_tab[0] = 4'h8;
    up_tab[1] = 4'h8;
    up_tab[2] = 4'h0;
    lo_val    = 4'h5;
    launch(1'b0, 1'b1, n);
    expect_read(n, 3, 8'h05, 1'b0);
    wait_done(500);

    // ---- Overlapping starts are ignored ----
    for (int i = 0; i < 8; i++) up_tab[i] = 4'h0;
    up_tab[0] = 4'h6;
    lo_val    = 4'hC;
    launch(1'b1, 1'b0, n);
    expect_read(n, 1, 8'h6C, 1'b0);
    wait_until(n + 20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(n + 100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    repeat (10) @(negedge clk);
    check("overlap_no_retrigger", rd_active, 1'b0);

    // ---- Reset during E_L discards the read ----
    up_tab[0] = 4'h3;
    lo_val    = 4'h9;
    launch(1'b1, 1'b0, n);
    wait_until(n + 70);
    reset = 1'b1;
    #1;
    check("rst_el_lcd_e", LCD_E, 1'b0);
    check("rst_el_rd_active", rd_active, 1'b0);
    check("rst_el_data_out", data_out, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (150) @(negedge clk);
    check("rst_el_stay_idle", rd_active, 1'b0);

    // Fresh read after the abort completes in exactly T
    up_tab[0] = 4'hA;
    lo_val    = 4'h7;
    launch(1'b1, 1'b0, n);
    expect_read(n, 1, 8'hA7, 1'b0);
    wait_done(200);

    // ---- Busy flag stuck at 1 ----
    for (int i = 0; i < 8; i++) up_tab[i] = 4'h8;
    lo_val = 4'h3;
`ifdef LCD_RD_TIMEOUT_EN
    launch(1'b0, 1'b1, n);
    expect_read(n, 4, 8'h83, 1'b1);
    wait_done(700);
    check("timeout_bf_bit", data_out[7], 1'b1);
`else
    launch(1'b0, 1'b1, n);
    to_seen = 1'b0;
    while (cyc < n + 10 * T_READ) begin
      @(negedge clk);
      to_seen = to_seen | timeout;
    end
    check("unbounded_still_active", rd_active, 1'b1);
    check("unbounded_no_timeout", to_seen, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
